bcd_sseg_scan: RTL

Two-digit seven-segment scan driver sitting directly downstream of the 6-bit binary-to-BCD converter. It captures the converter's `ones`/`tens` digits on a load strobe, buffers them so that updates only take effect at frame boundaries, and time-multiplexes them onto a 4-anode, active-low seven-segment display. Each digit is followed by an anti-ghosting blank gap.

---
 rtl/bcd_sseg_pkg.sv | 23 ++
 rtl/sseg_decode.sv | 27 ++
 rtl/bcd_sseg_scan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_sseg_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
// Segment and anode values are active-low.
package bcd_sseg_pkg;

  typedef enum logic [1:0] {
    S_ON0  = 2'd0,
    S_GAP0 = 2'd1,
    S_ON1  = 2'd2,
    S_GAP1 = 2'd3
  } sseg_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
// Zero latency, no flow control; codes 10-15 render as a dash.
module sseg_decode
  import bcd_sseg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sseg_scan.sv
// Two-digit scan driver: loads buffered and applied at frame ends, load-to-lit 1..2*(REFRESH+GAP) cycles; never stalls.
// Optional BCD_SSEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_sseg_scan
  import bcd_sseg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int GAP_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CNT_MAX = max_int(REFRESH_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  sseg_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             phase_done;

  logic [3:0] pend_ones;
  logic [3:0] pend_tens;
  logic       pend_valid;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;

  logic [3:0] dec_digit;
  logic [6:0] dec_seg;

  always_comb begin
    phase_done = 1'b0;
    unique case (state)
      S_ON0, S_ON1:   phase_done = (cnt == ON_LAST);
      S_GAP0, S_GAP1: phase_done = (cnt == GAP_LAST);
      default:        phase_done = 1'b0;
    endcase
  end

  assign frame = (state == S_GAP1) && (cnt == GAP_LAST);

  // Reset parks in the last gap so the first frame edge promotes fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_GAP1;
      cnt   <= '0;
    end else if (phase_done) begin
      cnt <= '0;
      unique case (state)
        S_ON0:   state <= S_GAP0;
        S_GAP0:  state <= S_ON1;
        S_ON1:   state <= S_GAP1;
        S_GAP1:  state <= S_ON0;
        default: state <= S_GAP1;
      endcase
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A load in the frame cycle goes straight to the display, skipping the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ones  <= '0;
      pend_tens  <= '0;
      pend_valid <= 1'b0;
      disp_ones  <= '0;
      disp_tens  <= '0;
    end else if (frame) begin
      pend_valid <= 1'b0;
      if (load) begin
        disp_ones <= ones;
        disp_tens <= tens;
      end else if (pend_valid) begin
        disp_ones <= pend_ones;
        disp_tens <= pend_tens;
      end
    end else if (load) begin
      pend_ones  <= ones;
      pend_tens  <= tens;
      pend_valid <= 1'b1;
    end
  end

  assign dec_digit = (state == S_ON1) ? disp_tens : disp_ones;

  sseg_decode u_decode (
    .digit (dec_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    unique case (state)
      S_ON0: begin
        an  = AN_D0;
        seg = dec_seg;
      end
      S_ON1: begin
`ifdef BCD_SSEG_LEADING_ZERO_BLANK_EN
        if (disp_tens != 4'd0) begin
          an  = AN_D1;
          seg = dec_seg;
        end
`else
        an  = AN_D1;
        seg = dec_seg;
`endif
      end
      default: begin
        an  = AN_OFF;
        seg = SEG_BLANK;
      end
    endcase
  end

  assign dp = 1'b1;

endmodule
